alu_arbiter: RTL and testbench

Shares one instance of the core's `alu` between `NUM_REQ` requesters, such as the execute stage, the address-generation path and the debug/CSR path. Arbitration is round-robin. Each requester gets a one-entry registered response slot with valid/ready backpressure. Sustained throughput is one ALU operation per cycle across all requesters. Response latency is one cycle.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/alu.sv | 38 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/alu_arbiter.sv | 92 +++++++++
 tb/tb_alu_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: ALU operation codes, data width and the largest
// requester count any shared-resource arbiter in the core is built for.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int MAX_REQ = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// Core ALU, purely combinational.
// Ports:
//   op     : 4-bit operation code (alu_op_e; codes 0xA-0xF give 0)
//   a, b   : operands
//   result : operation result
//   zero   : high when result is 0
// Shift amounts use the whole of b: shifting by 32 or more gives 0 for
// logical shifts and a full sign fill for SRA.
module alu
  import riscv_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b;
      ALU_SRL:  result = a >> b;
      ALU_SRA:  result = XLEN'($signed(a) >>> b);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Ports:
//   eligible   : one bit per requester
//   last_grant : index of the most recent winner
//   grant      : one-hot winner, zero when nobody is eligible
// The search starts one past last_grant and wraps around.
module rr_arbiter #(
  parameter int N   = 2,
  parameter int LGW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   eligible,
  input  logic [LGW-1:0] last_grant,
  output logic [N-1:0]   grant
);

  logic [LGW-1:0] idx;
  logic           found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = LGW'((int'(last_grant) + k) % N);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares a single ALU between NUM_REQ requesters with round-robin
// arbitration and a one-entry registered response slot per requester.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   req_valid   : request per requester
//   req_ready   : one-hot acceptance (zero while in reset)
//   req_op      : ALU operation code per requester
//   req_a/req_b : operands per requester
//   rsp_valid   : response slot occupied
//   rsp_ready   : requester consumes its response
//   rsp_result  : registered ALU result
//   rsp_zero    : registered zero flag
module alu_arbiter
  import riscv_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][3:0]       req_op,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_a,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_b,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ-1:0][XLEN-1:0]  rsp_result,
  output logic [NUM_REQ-1:0]            rsp_zero
);

  localparam int LGW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [LGW-1:0]     last_grant;
  logic [LGW-1:0]     gidx;
  logic [3:0]         alu_op;
  logic [XLEN-1:0]    alu_a;
  logic [XLEN-1:0]    alu_b;
  logic [XLEN-1:0]    alu_res;
  logic               alu_zero;

  // A full slot can still accept if it is being drained this cycle.
  assign eligible  = req_valid & (~rsp_valid | rsp_ready);
  assign req_ready = rst_n ? grant : '0;

  rr_arbiter #(.N(NUM_REQ), .LGW(LGW)) u_rr_arbiter (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gidx = LGW'(i);
    end
  end

  assign alu_op = req_op[gidx];
  assign alu_a  = req_a[gidx];
  assign alu_b  = req_b[gidx];

  alu u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= LGW'(NUM_REQ - 1);
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_zero   <= '0;
    end else begin
      if (|grant) last_grant <= gidx;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          rsp_valid[i]  <= 1'b1;
          rsp_result[i] <= alu_res;
          rsp_zero[i]   <= alu_zero;
        end else if (rsp_ready[i]) begin
          rsp_valid[i]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int N = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0][3:0]    req_op;
  logic [N-1:0][31:0]   req_a;
  logic [N-1:0][31:0]   req_b;
  logic [N-1:0]         rsp_valid;
  logic [N-1:0]         rsp_ready;
  logic [N-1:0][31:0]   rsp_result;
  logic [N-1:0]         rsp_zero;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: what each response slot should hold and who won last.
  bit          m_valid [N];
  logic [31:0] m_res   [N];
  bit          m_zero  [N];
  int          m_last;
  int          last_g;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (b >= 32) ? 32'd0 : a * (32'd1 << b);
      4'd6: return (b >= 32) ? 32'd0 : a / (32'd1 << b);
      4'd7: begin
        if (b >= 32) return a[31] ? 32'hFFFF_FFFF : 32'd0;
        // arithmetic shift right as floor division by a power of two
        if (sa >= 0) return 32'(sa / (64'sd1 << b));
        return 32'(-((-sa + (64'sd1 << b) - 1) / (64'sd1 << b)));
      end
      4'd8: return (sa < sb) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_grant();
    int j;
    for (int k = 1; k <= N; k++) begin
      j = (m_last + k) % N;
      if (req_valid[j] && (!m_valid[j] || rsp_ready[j])) return j;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs must be set before calling; checks req_ready, advances one clock,
  // updates the reference and checks every response slot.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_rdy;
    #1;
    g = rst_n ? exp_grant() : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0;
        m_res[i]   = '0;
        m_zero[i]  = 0;
      end
      m_last = N - 1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i == g) begin
          m_valid[i] = 1;
          m_res[i]   = ref_alu(req_op[i], req_a[i], req_b[i]);
          m_zero[i]  = (m_res[i] == 0);
        end else if (rsp_ready[i]) begin
          m_valid[i] = 0;
        end
      end
      if (g >= 0) m_last = g;
    end
    last_g = g;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(m_valid[i]));
      check($sformatf("rsp_result[%0d]", i), rsp_result[i], m_res[i]);
      check($sformatf("rsp_zero[%0d]", i), 32'(rsp_zero[i]), 32'(m_zero[i]));
    end
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{4'd0, 32'd5,         32'd7,  32'd12,        1'b0});
    vecs.push_back('{4'd1, 32'd9,         32'd9,  32'd0,         1'b1});
    vecs.push_back('{4'd8, 32'hFFFF_FFFF, 32'd1,  32'd1,         1'b0});
    vecs.push_back('{4'd9, 32'hFFFF_FFFF, 32'd1,  32'd0,         1'b1});
    vecs.push_back('{4'd7, 32'h8000_0000, 32'd4,  32'hF800_0000, 1'b0});
    vecs.push_back('{4'hF, 32'd123,       32'd45, 32'd0,         1'b1});
    vecs.push_back('{4'd5, 32'd1,         32'd40, 32'd0,         1'b1});
    vecs.push_back('{4'd7, 32'h8000_0000, 32'd33, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0});

    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    req_op = '0; req_a = '0; req_b = '0;
    last_g = -1; m_last = N - 1;
    for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_res[i] = '0; m_zero[i] = 0; end
    cycle();
    cycle();
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;

    // Table-driven ALU encodings on requester 0.
    foreach (vecs[v]) begin
      req_valid = 2'b01; rsp_ready = 2'b11;
      req_op[0] = vecs[v].op; req_a[0] = vecs[v].a; req_b[0] = vecs[v].b;
      cycle();
      check($sformatf("vec%0d_grant", v), 32'(last_g), 32'd0);
      check($sformatf("vec%0d_result", v), rsp_result[0], vecs[v].res);
      check($sformatf("vec%0d_zero", v), 32'(rsp_zero[0]), 32'(vecs[v].zero));
    end

    // Fill both slots, then reset with responses pending.
    req_valid = 2'b11; rsp_ready = 2'b00;
    req_op[0] = 4'd0; req_a[0] = 32'd10; req_b[0] = 32'd20;
    req_op[1] = 4'd3; req_a[1] = 32'h0F;  req_b[1] = 32'hF0;
    cycle();
    cycle();
    check("both_pending", 32'(rsp_valid), 32'h3);
    rst_n = 1'b0;
    #1;
    check("rdy_in_reset", 32'(req_ready), 32'd0);
    cycle();
    check("valid_after_reset", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;

    // Fair alternation starting from requester 0.
    rsp_ready = 2'b11;
    for (int c = 0; c < 6; c++) begin
      cycle();
      check($sformatf("alt%0d", c), 32'(last_g), 32'(c % 2));
    end

    // Backpressure on requester 0.
    rsp_ready = 2'b10;
    req_op[0] = 4'd1; req_a[0] = 32'd100; req_b[0] = 32'd1;
    cycle();
    check("bp_first", 32'(last_g), 32'd0);
    req_op[0] = 4'd4; req_a[0] = 32'h1234; req_b[0] = 32'h00FF;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check($sformatf("bp_req1_%0d", c), 32'(last_g), 32'd1);
      check($sformatf("bp_hold_%0d", c), rsp_result[0], 32'd99);
    end
    rsp_ready = 2'b11;
    cycle();
    check("bp_refill_grant", 32'(last_g), 32'd0);
    check("bp_refill_valid", 32'(rsp_valid[0]), 32'd1);
    check("bp_refill_result", rsp_result[0], 32'h12CB);

    // Randomized traffic against the reference.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && last_g != i)) begin
          req_valid[i] = ($urandom % 4) != 0;
          req_op[i] = 4'($urandom % 16);
          req_a[i]  = ($urandom % 3 == 0) ? 32'($urandom % 8) : $urandom;
          req_b[i]  = ($urandom % 2 == 0) ? 32'($urandom % 40) : $urandom;
        end
        rsp_ready[i] = ($urandom % 3) != 0;
      end
      if (c == 200) rst_n = 1'b0;
      else rst_n = 1'b1;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
